la_cfg_tx: RTL
==============

# la_cfg_tx

Configuration-frame transmitter for the logic analyzer's UART command link; the initiator end of the 5-byte setup protocol that the capture core receives. It latches a sample-mode/delay/trigger setting on a start strobe, appends the checksum byte, and serializes the frame as 8N1 UART, LSB first. It sits in a controller FPGA, or a loopback test build, that drives an analyzer's `uartrx` pin.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per UART bit (12 MHz / 115200).
- `GAP_BITS`, 2: idle (mark) bit periods inserted after every byte, including the last.
- `RESEND_CYCLES`, 24'd1200000: idle interval between automatic resends; used only with `LA_CFG_TX_RESEND_EN`.
- `freq_in` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request to send one frame; sampled only in IDLE.
- `rate_sel` in 5: sample-clock select code; frame byte0[4:0].
- `arm` in 1: capture enable; frame byte0[5].
- `trig_en` in 1: trigger-mode enable; frame byte0[6].
- `delay` in 8: post-trigger delay count; frame byte1.
- `trig_mask` in 8: trigger edge mask; frame byte2.
- `trig_val` in 8: trigger compare value; frame byte3.
- `uarttx` out 1: serial line, idle high.
- `busy` out 1: high from the first start-bit cycle through the end of the last gap.
- `done` out 1: one-cycle pulse when a frame completes.

## Operation
- Frame bytes:
  - b0 = {1'b0, trig_en, arm, rate_sel}
  - b1 = delay
  - b2 = trig_mask
  - b3 = trig_val
  - b4 = 8'hAA − (b0+b1+b2+b3), mod 256, so all five bytes sum to 8'hAA.
- On `start`=1 in IDLE, latch all operands into a 4-byte shadow register and compute b4 in the same edge. Later operand changes do not affect the frame in flight.
- `start` while `busy` is ignored; requests are not queued.
- FSM states and transitions:
  - IDLE → START: on start (or resend timer expiry).
  - START: 1 bit period, line 0 → DATA.
  - DATA: 8 bit periods, LSB first → STOP.
  - STOP: 1 bit period, line 1 → GAP.
  - GAP: GAP_BITS periods, line 1 → START if byte index < 4, else IDLE.
- Counters:
  - baud counter 0..CLKS_PER_BIT−1
  - bit index 0..7
  - byte index 0..4
  - gap counter 0..GAP_BITS−1
- All wrap to 0 on their terminal value.
- `uarttx` is registered; it is driven from state and the current shift bit, never combinationally from inputs.

## Timing
- Reset values (asynchronous, immediate): `uarttx`=1, `busy`=0, `done`=0, state=IDLE, all counters and shadow registers 0.
- Start latency: with `start` high at edge N in IDLE, `uarttx` falls and `busy` rises after edge N+1... registered at edge N; both are visible in cycle N+1.
- Bit duration: each bit holds exactly CLKS_PER_BIT cycles.
- Frame duration: 5·(10+GAP_BITS)·CLKS_PER_BIT cycles. Defaults give 6240.
- Completion: `done` is high for the single cycle in which `busy` returns to 0. A new `start` is accepted in that same cycle.
- Reset asserted mid-frame: the line returns to 1 at once and the partial frame is abandoned. The receiver discards it on checksum or timeout.
- Simultaneous `start` and resend-timer expiry: treated as a single `start`; fresh operands are latched.

## Configuration
- `LA_CFG_TX_RESEND_EN` defined:
  - After each `done`, a 24-bit timer counts RESEND_CYCLES idle cycles, then resends the latched frame unchanged.
  - An external `start` takes priority over the timer and restarts it.
  - Reset clears the timer; no resend occurs until a first `start` is accepted.
- `LA_CFG_TX_RESEND_EN` undefined:
  - No timer logic is present; frames are sent only on `start`.

## Test plan
- Reset/idle: hold rst_n=0, then release for 1000 cycles with start=0 → uarttx=1, busy=0, done never pulses.
- Basic frame: rate_sel=5'h04, arm=1, trig_en=0, delay=8'h10, trig_mask=8'h01, trig_val=8'h01, pulse start → decoded bytes 24,10,01,01,74 (hex). Each bit is 104 cycles; done occurs 6240 cycles after start.
- Checksum wrap: rate_sel=5'h1F, arm=1, trig_en=1, the other three bytes 8'hFF → bytes 7F,FF,FF,FF,2E. The bench-computed 5-byte sum equals AA.
- All-zero settings: all operands 0 → bytes 00,00,00,00,AA.
- Busy protection: operands change and start pulses again during byte 2 → no effect on the current frame and no second frame. A start in the done cycle is accepted and begins the next frame one cycle later.
- Mid-frame reset: assert rst_n=0 during byte 3 data → uarttx=1 within the same cycle and busy=0. After release, a fresh start sends the complete frame. With `LA_CFG_TX_RESEND_EN` and RESEND_CYCLES=1000, an identical frame repeats 1000 cycles after each done.

Source files
------------

// File: rtl/la_cfg_tx_if.sv
// la_cfg_tx_if: setup operands, start strobe and serial/status outputs of the config-frame transmitter
interface la_cfg_tx_if;
  logic       start;
  logic [4:0] rate_sel;
  logic       arm;
  logic       trig_en;
  logic [7:0] delay;
  logic [7:0] trig_mask;
  logic [7:0] trig_val;
  logic       uarttx;
  logic       busy;
  logic       done;
  modport master (
    output start, rate_sel, arm, trig_en, delay, trig_mask, trig_val,
    input  uarttx, busy, done
  );
  modport slave (
    input  start, rate_sel, arm, trig_en, delay, trig_mask, trig_val,
    output uarttx, busy, done
  );
endinterface

// File: rtl/la_cfg_tx.sv
// la_cfg_tx: 5-byte 8N1 setup-frame transmitter (bytes sum to 8'hAA); LA_CFG_TX_RESEND_EN adds periodic resend
module la_cfg_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int GAP_BITS = 2
`ifdef LA_CFG_TX_RESEND_EN
  , parameter logic [23:0] RESEND_CYCLES = 24'd1200000
`endif
) (
  input logic freq_in,
  input logic rst_n,
  la_cfg_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int GW = $clog2(GAP_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
  state_t state;
  logic [BW-1:0] baud;
  logic [GW-1:0] gap;
  logic [2:0] bit_idx, byte_idx;
  logic [7:0] b0, b1, b2, b3, ck, sh, n0, next_byte;
  logic go, bit_end;
  assign n0 = {1'b0, bus.trig_en, bus.arm, bus.rate_sel};
  assign bit_end = baud == BAUD_LAST;
  always_comb
    next_byte = byte_idx == 3'd0 ? b0 : byte_idx == 3'd1 ? b1 :
                byte_idx == 3'd2 ? b2 : byte_idx == 3'd3 ? b3 : ck;
`ifdef LA_CFG_TX_RESEND_EN
  logic [23:0] tmr;
  logic rs_arm;
  assign go = bus.start || (rs_arm && tmr == RESEND_CYCLES - 24'd1);
  // timer only runs in IDLE after a first accepted start; any launch restarts it
  always_ff @(posedge freq_in or negedge rst_n)
    if (!rst_n) begin
      tmr <= '0;
      rs_arm <= 1'b0;
    end else begin
      rs_arm <= rs_arm | (state == IDLE && bus.start);
      tmr <= (state != IDLE || go) ? '0 : rs_arm ? tmr + 24'd1 : '0;
    end
`else
  assign go = bus.start;
`endif
  always_ff @(posedge freq_in or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      baud <= '0;
      gap <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      {b0, b1, b2, b3, ck, sh} <= '0;
      bus.uarttx <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (go) begin
          // a resend reuses the shadow bytes; only an external start refreshes them
          if (bus.start) begin
            b0 <= n0;
            b1 <= bus.delay;
            b2 <= bus.trig_mask;
            b3 <= bus.trig_val;
            ck <= 8'hAA - (n0 + bus.delay + bus.trig_mask + bus.trig_val);
          end
          state <= START;
          byte_idx <= '0;
          bus.uarttx <= 1'b0;
          bus.busy <= 1'b1;
        end
        START: if (bit_end) begin
          state <= DATA;
          bus.uarttx <= next_byte[0];
          sh <= {1'b0, next_byte[7:1]};
        end
        DATA: if (bit_end) begin
          bit_idx <= bit_idx + 3'd1;
          state <= bit_idx == 3'd7 ? STOP : DATA;
          bus.uarttx <= bit_idx == 3'd7 ? 1'b1 : sh[0];
          sh <= {1'b0, sh[7:1]};
        end
        STOP: if (bit_end) state <= GAP;
        GAP: if (bit_end) begin
          gap <= gap == GAP_LAST ? '0 : gap + 1'b1;
          if (gap == GAP_LAST) begin
            byte_idx <= byte_idx == 3'd4 ? 3'd0 : byte_idx + 3'd1;
            state <= byte_idx == 3'd4 ? IDLE : START;
            bus.uarttx <= byte_idx == 3'd4;
            bus.busy <= byte_idx != 3'd4;
            bus.done <= byte_idx == 3'd4;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
